// File: rtl/uart_core_param_if.sv
// rtl/uart_core_param_if.sv - byte-level valid/ready interface of uart_core_param
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised UART core with mid-bit sampling and valid/ready byte handshakes
module uart_core_param #(
    parameter int CLKS_PER_BIT = 108,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic uart_rx,
    output logic uart_tx,
    uart_core_param_if.slave bus
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_bit;
    logic                 tx_stop;
    logic [DATA_BITS-1:0] tx_buf;
    logic                 tx_armed, tx_ready, tx_fire, tx_bit_end, tx_frame_end;

    assign tx_bit_end   = (tx_cnt == CNT_LAST);
    assign tx_frame_end = (tx_state == S_STOP) && tx_bit_end && (tx_stop == STOP_LAST);
    assign tx_fire      = bus.tx_valid && tx_ready;
    assign bus.tx_ready = tx_ready;

    always_ff @(posedge clk) begin
        if (!rstn) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_fire) tx_next = S_START;
            S_START:  if (tx_bit_end) tx_next = S_DATA;
            S_DATA:   if (tx_bit_end && tx_bit == BIT_LAST) tx_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_next = S_STOP;
            S_STOP:   if (tx_frame_end) tx_next = tx_fire ? S_START : S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    // Ready in the last stop cycle lets a new byte start with no idle gap.
    always_comb begin
        tx_ready = tx_armed && (tx_state == S_IDLE || tx_frame_end);
        uart_tx  = 1'b1;
        case (tx_state)
            S_START:  uart_tx = 1'b0;
            S_DATA:   uart_tx = tx_buf[tx_bit];
            S_PARITY: uart_tx = (^tx_buf) ^ ODD;
            default:  uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_armed <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_buf   <= '0;
        end else begin
            tx_armed <= 1'b1;
            if (tx_fire) begin
                tx_buf  <= bus.tx_data;
                tx_cnt  <= '0;
                tx_bit  <= '0;
                tx_stop <= 1'b0;
            end else if (tx_state != S_IDLE) begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_ONE;
                if (tx_state == S_DATA && tx_bit_end) tx_bit <= tx_bit + 3'd1;
                if (tx_state == S_STOP && tx_bit_end) tx_stop <= ~tx_stop;
            end
        end
    end

    logic [1:0]           rx_sync;
    logic                 rxs;
    state_t               rx_state, rx_next;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift, rx_data;
    logic                 rx_done, rx_ferr, rx_perr, rx_bit_end, rx_mid_start;
    logic                 take_data, take_par, take_stop;
    logic                 rx_valid, rx_frame_err, rx_parity_err, rx_overrun;

    assign rxs          = rx_sync[1];
    assign rx_bit_end   = (rx_cnt == CNT_LAST);
    assign rx_mid_start = (rx_cnt == CNT_HALF);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_sync  <= 2'b11;
            rx_state <= S_IDLE;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx};
            rx_state <= rx_next;
        end
    end

    // A start bit that is high again at its midpoint is treated as a glitch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (!rxs) rx_next = S_START;
            S_START:  if (rx_mid_start) rx_next = rxs ? S_IDLE : S_DATA;
            S_DATA:   if (rx_bit_end && rx_bit == BIT_LAST) rx_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (rx_bit_end) rx_next = S_STOP;
            S_STOP:   if (rx_bit_end) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        take_data = 1'b0;
        take_par  = 1'b0;
        take_stop = 1'b0;
        case (rx_state)
            S_DATA:   take_data = rx_bit_end;
            S_PARITY: take_par  = rx_bit_end;
            S_STOP:   take_stop = rx_bit_end;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= take_stop;
            if (rx_state == S_IDLE || (rx_state == S_START && rx_mid_start) ||
                (rx_state != S_START && rx_bit_end))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CNT_ONE;
            if (rx_state == S_IDLE) begin
                rx_bit  <= '0;
                rx_perr <= 1'b0;
            end
            if (take_data) begin
                rx_shift[rx_bit] <= rxs;
                rx_bit           <= rx_bit + 3'd1;
            end
            if (take_par)  rx_perr <= rxs ^ (^rx_shift) ^ ODD;
            if (take_stop) rx_ferr <= ~rxs;
        end
    end

    // Holding register: a frame arriving while the previous one is unconsumed is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_valid && bus.rx_ready) rx_valid <= 1'b0;
            if (rx_done) begin
                if (!rx_valid || bus.rx_ready) begin
                    rx_data       <= rx_shift;
                    rx_frame_err  <= rx_ferr;
                    rx_parity_err <= rx_perr;
                    rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.rx_data       = rx_data;
    assign bus.rx_valid      = rx_valid;
    assign bus.rx_frame_err  = rx_frame_err;
    assign bus.rx_parity_err = rx_parity_err;
    assign bus.rx_overrun    = rx_overrun;
endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - directed-vector bench for uart_core_param (8N1 and 8E2 instances)
module tb_uart_core_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic a_rx, a_tx;
    logic b_rx, b_tx, b_rx_drv, b_loop;
    assign b_rx = b_loop ? b_tx : b_rx_drv;

    uart_core_param_if #(.DATA_BITS(8)) a_if ();
    uart_core_param_if #(.DATA_BITS(8)) b_if ();

    uart_core_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rstn(rstn), .uart_rx(a_rx), .uart_tx(a_tx), .bus(a_if)
    );
    uart_core_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rstn(rstn), .uart_rx(b_rx), .uart_tx(b_tx), .bus(b_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ovr_total = 0;

    always @(negedge clk) if (a_if.rx_overrun === 1'b1) ovr_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Samples the line every cycle; bits[i] is the mid-bit sample, bad counts cycles that disagree with it.
    task automatic capture_tx(input bit sel, input int nbits, output logic [15:0] bits,
                              output int bad, output int ready_at);
        logic [255:0] samp;
        samp = '0;
        bits = '0;
        bad = 0;
        ready_at = -1;
        for (int k = 0; k < nbits * 16; k++) begin
            samp[k] = sel ? b_tx : a_tx;
            if (ready_at < 0 && (sel ? b_if.tx_ready : a_if.tx_ready) === 1'b1) ready_at = k;
            tick();
        end
        for (int i = 0; i < nbits; i++) begin
            bits[i] = samp[i * 16 + 8];
            for (int j = 0; j < 16; j++) if (samp[i * 16 + j] !== bits[i]) bad++;
        end
    endtask

    // Drives an LSB-first bit vector onto an rx line; ready_k pulses a_if.rx_ready for one edge.
    task automatic drive_frame(input bit sel, input logic [15:0] bits, input int nbits, input int ready_k);
        for (int k = 0; k < nbits * 16; k++) begin
            if (sel) b_rx_drv = bits[k / 16];
            else begin
                a_rx = bits[k / 16];
                a_if.rx_ready = (k == ready_k);
            end
            tick();
        end
        if (sel) b_rx_drv = 1'b1;
        else begin
            a_rx = 1'b1;
            a_if.rx_ready = 1'b0;
        end
        tick(20);
    endtask

    initial begin
        logic [15:0] bits;
        int bad, rdy, ovr0;

        rstn = 1'b0;
        a_rx = 1'b1; b_rx_drv = 1'b1; b_loop = 1'b0;
        a_if.tx_data = '0; a_if.tx_valid = 1'b0; a_if.rx_ready = 1'b0;
        b_if.tx_data = '0; b_if.tx_valid = 1'b0; b_if.rx_ready = 1'b0;
        tick(3);
        check("rst uart_tx", a_tx, 1);
        check("rst tx_ready", a_if.tx_ready, 0);
        check("rst rx_valid", a_if.rx_valid, 0);
        check("rst rx_data", a_if.rx_data, 0);
        check("rst err flags", {a_if.rx_frame_err, a_if.rx_parity_err, a_if.rx_overrun}, 0);
        rstn = 1'b1;
        check("tx_ready before first edge", a_if.tx_ready, 0);
        tick();
        check("tx_ready after release", a_if.tx_ready, 1);

        // 8N1 0xA5 then back-to-back 0x3C
        a_if.tx_data = 8'hA5; a_if.tx_valid = 1'b1;
        tick();
        a_if.tx_data = 8'h3C;
        capture_tx(0, 10, bits, bad, rdy);
        check("t1 A5 frame bits", bits[9:0], 10'h34A);
        check("t1 A5 bit length", bad, 0);
        check("t1 tx_ready first high", rdy, 159);
        a_if.tx_valid = 1'b0;
        capture_tx(0, 10, bits, bad, rdy);
        check("t1 3C frame bits", bits[9:0], 10'h278);
        check("t1 3C bit length no gap", bad, 0);
        tick(5);
        check("t1 line idle", a_tx, 1);

        // 8E2 loopback 0x37
        b_loop = 1'b1;
        b_if.tx_data = 8'h37; b_if.tx_valid = 1'b1;
        tick();
        b_if.tx_valid = 1'b0;
        capture_tx(1, 12, bits, bad, rdy);
        check("t2 frame bits", bits[11:0], 12'hE6E);
        check("t2 parity bit", bits[9], 1);
        check("t2 bit length", bad, 0);
        check("t2 rx_valid", b_if.rx_valid, 1);
        check("t2 rx_data", b_if.rx_data, 8'h37);
        check("t2 parity_err", b_if.rx_parity_err, 0);
        check("t2 frame_err", b_if.rx_frame_err, 0);
        b_if.rx_ready = 1'b1;
        tick();
        b_if.rx_ready = 1'b0;
        check("t2 rx_valid consumed", b_if.rx_valid, 0);
        b_loop = 1'b0;

        // start glitch
        a_rx = 1'b0;
        tick(5);
        a_rx = 1'b1;
        tick(40);
        check("t3 glitch rx_valid", a_if.rx_valid, 0);

        // 0x55 with stop bit 0
        drive_frame(0, 16'h00AA, 10, -1);
        check("t4 ferr rx_valid", a_if.rx_valid, 1);
        check("t4 ferr rx_data", a_if.rx_data, 8'h55);
        check("t4 frame_err", a_if.rx_frame_err, 1);
        check("t4 ferr parity_err", a_if.rx_parity_err, 0);
        a_if.rx_ready = 1'b1;
        tick();
        a_if.rx_ready = 1'b0;
        check("t4 ferr consumed", a_if.rx_valid, 0);

        // 0x55 with parity bit flipped to 1
        drive_frame(1, 16'h0EAA, 12, -1);
        check("t4 perr rx_valid", b_if.rx_valid, 1);
        check("t4 perr rx_data", b_if.rx_data, 8'h55);
        check("t4 parity_err", b_if.rx_parity_err, 1);
        check("t4 perr frame_err", b_if.rx_frame_err, 0);
        b_if.rx_ready = 1'b1;
        tick();
        b_if.rx_ready = 1'b0;

        // overrun, then same-edge consume
        drive_frame(0, 16'h0222, 10, -1);
        check("t5 first rx_data", a_if.rx_data, 8'h11);
        ovr0 = ovr_total;
        drive_frame(0, 16'h0244, 10, -1);
        check("t5 overrun pulse count", ovr_total - ovr0, 1);
        check("t5 data kept", a_if.rx_data, 8'h11);
        check("t5 still valid", a_if.rx_valid, 1);
        ovr0 = ovr_total;
        drive_frame(0, 16'h0244, 10, 155);
        check("t5 no overrun", ovr_total - ovr0, 0);
        check("t5 new data", a_if.rx_data, 8'h22);
        check("t5 new valid", a_if.rx_valid, 1);

        // reset mid-DATA
        a_if.tx_data = 8'h00; a_if.tx_valid = 1'b1;
        tick();
        a_if.tx_valid = 1'b0;
        tick(56);
        check("t6 line low in data", a_tx, 0);
        rstn = 1'b0;
        tick();
        check("t6 reset uart_tx", a_tx, 1);
        check("t6 reset tx_ready", a_if.tx_ready, 0);
        check("t6 reset rx_valid", a_if.rx_valid, 0);
        rstn = 1'b1;
        check("t6 ready before edge", a_if.tx_ready, 0);
        tick();
        check("t6 ready after edge", a_if.tx_ready, 1);
        a_if.tx_data = 8'hF0; a_if.tx_valid = 1'b1;
        tick();
        a_if.tx_valid = 1'b0;
        capture_tx(0, 10, bits, bad, rdy);
        check("t6 F0 frame bits", bits[9:0], 10'h3E0);
        check("t6 F0 bit length", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
